// File: rtl/iob_eth_rx_pkg.sv
// Shared types and constants for the Ethernet MII/GMII receive framer:
// FSM states, preamble/SFD codes and the CRC-32 step used when CRC checking is built in.
package iob_eth_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_DROP     = 2'd3
    } rx_state_e;

    localparam logic [3:0]  PREAMBLE_NIB  = 4'h5;
    localparam logic [3:0]  SFD_NIB       = 4'hD;
    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;

    localparam logic [31:0] CRC_POLY      = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hC704_DD7B;

    // MSB-first register fed with data bits LSB-first; the good-frame residue
    // of this form is the bit-reversal of the reflected 0xDEBB20E3.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[31] ^ d[i]) c = {c[30:0], 1'b0} ^ CRC_POLY;
            else              c = {c[30:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/iob_eth_rx_fifo.sv
// Synchronous show-ahead FIFO of {err, last, data} entries. A push into a full
// FIFO is accepted only when a pop happens in the same cycle; clr_i empties it.
module iob_eth_rx_fifo
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int W          = 10
)
(
    input  logic         clk_i,
    input  logic         arst_n_i,
    input  logic         clr_i,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] pop_data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [W-1:0]          r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign full_o     = (r_count == (DEPTH_LOG2 + 1)'(DEPTH));
    assign empty_o    = (r_count == '0);
    assign w_do_pop   = pop_i && !empty_o;
    assign w_do_push  = push_i && (!full_o || w_do_pop);
    assign pop_data_o = empty_o ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk_i) begin
        if (w_do_push) r_mem[r_wr_ptr] <= push_data_i;
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clr_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/iob_eth_mii_rx_framer.sv
// MII/GMII receive framer: strips preamble/SFD, assembles bytes and streams them with
// last/err marking through a FIFO. Define IOB_ETH_RX_CRC_EN to add FCS checking.
module iob_eth_mii_rx_framer
    import iob_eth_rx_pkg::*;
#(
    parameter int PHY_DATA_W      = 4,
    parameter int FIFO_DEPTH_LOG2 = 4
)
(
    input  logic                  clk_i,
    input  logic                  arst_n_i,
    input  logic                  en_i,
    input  logic                  phy_rx_dv_i,
    input  logic                  phy_rx_er_i,
    input  logic [PHY_DATA_W-1:0] phy_rx_data_i,
    output logic [7:0]            m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic                  m_last_o,
    output logic                  m_err_o,
    output logic [15:0]           frame_cnt_o,
    output logic [15:0]           drop_cnt_o,
    output logic                  busy_o
);

    localparam bit NIB_MODE = (PHY_DATA_W == 4);

    rx_state_e   r_state, w_state_nxt;
    logic        r_pre_seen, w_pre_seen_nxt;
    logic        r_nib_odd, w_nib_odd_nxt;
    logic [3:0]  r_low_nib, w_low_nib_nxt;
    logic        r_stage_valid, w_stage_valid_nxt;
    logic [7:0]  r_stage_data, w_stage_data_nxt;
    logic        r_pend, w_pend_nxt;
    logic        r_frame_err, w_frame_err_nxt;
    logic [15:0] r_frame_cnt, w_frame_cnt_nxt;
    logic [15:0] r_drop_cnt, w_drop_cnt_nxt;

    logic        w_push;
    logic [9:0]  w_push_data;
    logic [9:0]  w_fifo_out;
    logic        w_fifo_full, w_fifo_empty;
    logic        w_pop, w_space, w_clr;
    logic [7:0]  w_unit, w_byte;
    logic        w_is_pre, w_is_sfd, w_crc_bad, w_end_err;

    assign w_unit    = 8'(phy_rx_data_i);
    assign w_is_pre  = NIB_MODE ? (w_unit[3:0] == PREAMBLE_NIB) : (w_unit == PREAMBLE_BYTE);
    assign w_is_sfd  = NIB_MODE ? (w_unit[3:0] == SFD_NIB)      : (w_unit == SFD_BYTE);
    assign w_byte    = NIB_MODE ? {w_unit[3:0], r_low_nib} : w_unit;
    assign w_pop     = m_valid_o && m_ready_i;
    assign w_space   = !w_fifo_full || w_pop;
    assign w_clr     = !en_i;
    assign w_end_err = r_frame_err | r_nib_odd | w_crc_bad;

`ifdef IOB_ETH_RX_CRC_EN
    logic [31:0] r_crc;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i)                           r_crc <= CRC_INIT;
        else if (!en_i || r_state != ST_DATA)    r_crc <= CRC_INIT;
        else if (phy_rx_dv_i && (!NIB_MODE || r_nib_odd))
                                                 r_crc <= crc32_byte(r_crc, w_byte);
    end

    assign w_crc_bad = (r_crc != CRC_RESIDUE);
`else
    assign w_crc_bad = 1'b0;
`endif

    always_comb begin
        w_state_nxt       = r_state;
        w_pre_seen_nxt    = 1'b0;
        w_nib_odd_nxt     = r_nib_odd;
        w_low_nib_nxt     = r_low_nib;
        w_stage_valid_nxt = r_stage_valid;
        w_stage_data_nxt  = r_stage_data;
        w_pend_nxt        = r_pend;
        w_frame_err_nxt   = r_frame_err;
        w_frame_cnt_nxt   = r_frame_cnt;
        w_drop_cnt_nxt    = r_drop_cnt;
        w_push            = 1'b0;
        w_push_data       = '0;

        // A staged last byte left behind by a full FIFO leaves at the first free slot.
        if (r_pend && w_space) begin
            w_push            = 1'b1;
            w_push_data       = {r_frame_err, 1'b1, r_stage_data};
            w_pend_nxt        = 1'b0;
            w_stage_valid_nxt = 1'b0;
            w_frame_err_nxt   = 1'b0;
            w_frame_cnt_nxt   = r_frame_cnt + 16'd1;
        end

        case (r_state)
            ST_IDLE, ST_PREAMBLE: begin
                if (!phy_rx_dv_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_pend) begin
                    w_state_nxt    = ST_DROP;
                    w_drop_cnt_nxt = r_drop_cnt + 16'd1;
                end else if (w_is_pre) begin
                    w_state_nxt    = ST_PREAMBLE;
                    w_pre_seen_nxt = 1'b1;
                end else if (w_is_sfd && r_pre_seen) begin
                    w_state_nxt     = ST_DATA;
                    w_nib_odd_nxt   = 1'b0;
                    w_frame_err_nxt = 1'b0;
                end else begin
                    w_state_nxt    = ST_DROP;
                    w_drop_cnt_nxt = r_drop_cnt + 16'd1;
                end
            end
            ST_DATA: begin
                if (phy_rx_dv_i) begin
                    if (phy_rx_er_i) w_frame_err_nxt = 1'b1;
                    if (NIB_MODE && !r_nib_odd) begin
                        w_low_nib_nxt = w_unit[3:0];
                        w_nib_odd_nxt = 1'b1;
                    end else begin
                        w_nib_odd_nxt = 1'b0;
                        if (!r_stage_valid) begin
                            w_stage_valid_nxt = 1'b1;
                            w_stage_data_nxt  = w_byte;
                        end else if (w_space) begin
                            w_push           = 1'b1;
                            w_push_data      = {2'b00, r_stage_data};
                            w_stage_data_nxt = w_byte;
                        end else begin
                            // Overflow: new byte lost, staged byte becomes the errored last.
                            w_frame_err_nxt = 1'b1;
                            w_pend_nxt      = 1'b1;
                            w_state_nxt     = ST_DROP;
                        end
                    end
                end else begin
                    w_state_nxt   = ST_IDLE;
                    w_nib_odd_nxt = 1'b0;
                    if (!r_stage_valid) begin
                        w_drop_cnt_nxt  = r_drop_cnt + 16'd1;
                        w_frame_err_nxt = 1'b0;
                    end else if (w_space) begin
                        w_push            = 1'b1;
                        w_push_data       = {w_end_err, 1'b1, r_stage_data};
                        w_stage_valid_nxt = 1'b0;
                        w_frame_err_nxt   = 1'b0;
                        w_frame_cnt_nxt   = r_frame_cnt + 16'd1;
                    end else begin
                        w_pend_nxt      = 1'b1;
                        w_frame_err_nxt = w_end_err;
                    end
                end
            end
            ST_DROP: begin
                if (!phy_rx_dv_i) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        if (!en_i) begin
            w_state_nxt       = ST_IDLE;
            w_pre_seen_nxt    = 1'b0;
            w_nib_odd_nxt     = 1'b0;
            w_low_nib_nxt     = '0;
            w_stage_valid_nxt = 1'b0;
            w_stage_data_nxt  = '0;
            w_pend_nxt        = 1'b0;
            w_frame_err_nxt   = 1'b0;
            w_frame_cnt_nxt   = '0;
            w_drop_cnt_nxt    = '0;
            w_push            = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_state       <= ST_IDLE;
            r_pre_seen    <= 1'b0;
            r_nib_odd     <= 1'b0;
            r_low_nib     <= '0;
            r_stage_valid <= 1'b0;
            r_stage_data  <= '0;
            r_pend        <= 1'b0;
            r_frame_err   <= 1'b0;
            r_frame_cnt   <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_pre_seen    <= w_pre_seen_nxt;
            r_nib_odd     <= w_nib_odd_nxt;
            r_low_nib     <= w_low_nib_nxt;
            r_stage_valid <= w_stage_valid_nxt;
            r_stage_data  <= w_stage_data_nxt;
            r_pend        <= w_pend_nxt;
            r_frame_err   <= w_frame_err_nxt;
            r_frame_cnt   <= w_frame_cnt_nxt;
            r_drop_cnt    <= w_drop_cnt_nxt;
        end
    end

    iob_eth_rx_fifo #(
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
        .W          (10)
    ) u_fifo (
        .clk_i       (clk_i),
        .arst_n_i    (arst_n_i),
        .clr_i       (w_clr),
        .push_i      (w_push),
        .push_data_i (w_push_data),
        .pop_i       (m_ready_i),
        .pop_data_o  (w_fifo_out),
        .full_o      (w_fifo_full),
        .empty_o     (w_fifo_empty)
    );

    assign m_valid_o   = !w_fifo_empty;
    assign m_data_o    = w_fifo_out[7:0];
    assign m_last_o    = w_fifo_out[8];
    assign m_err_o     = w_fifo_out[9];
    assign frame_cnt_o = r_frame_cnt;
    assign drop_cnt_o  = r_drop_cnt;
    assign busy_o      = (r_state != ST_IDLE) || r_stage_valid;

endmodule
